// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: operand/accumulator/shift registers and bit counter,
// sequenced cycle by cycle by the Booth control unit through a 3-bit state code.
module booth_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [WIDTH-1:0]     multiplicand,
  input  logic signed [WIDTH-1:0]     multiplier,
  input  logic        [2:0]           control,
  output logic        [2:0]           status,
  output logic signed [2*WIDTH-1:0]   product,
  output logic                        product_valid
);

  localparam logic [2:0] C_INIT   = 3'b000;
  localparam logic [2:0] C_ADD    = 3'b001;
  localparam logic [2:0] C_SUB    = 3'b010;
  localparam logic [2:0] C_SHIFT  = 3'b011;
  localparam logic [2:0] C_CHOOSE = 3'b100;

  logic signed [WIDTH:0]   m_r;
  logic signed [WIDTH:0]   a_r;
  logic        [WIDTH-1:0] q_r;
  logic                    q_1_r;
  logic        [CNT_W-1:0] cnt_r;
  logic                    pv_r;
  logic                    fin;

  // Guard bit of A is the sign copy, so the shift replicates A[WIDTH] into the top.
  function automatic logic [2*WIDTH+1:0] asr_aqq1(input logic signed [WIDTH:0] a,
                                                  input logic [WIDTH-1:0] q);
    return {a[WIDTH], a, q};
  endfunction

  assign fin = (cnt_r == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      m_r   <= '0;
      a_r   <= '0;
      q_r   <= '0;
      q_1_r <= 1'b0;
      cnt_r <= '0;
      pv_r  <= 1'b0;
    end else begin
      case (control)
        C_INIT: begin
          if (start) begin
            m_r   <= {multiplicand[WIDTH-1], multiplicand};
            a_r   <= '0;
            q_r   <= multiplier;
            q_1_r <= 1'b0;
            cnt_r <= '0;
            pv_r  <= 1'b0;
          end
        end
        C_ADD: a_r <= a_r + m_r;
        C_SUB: a_r <= a_r - m_r;
        C_SHIFT: begin
          {a_r, q_r, q_1_r} <= asr_aqq1(a_r, q_r);
          if (fin) begin
            cnt_r <= '0;
            pv_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: ; // CHOOSE and reserved codes hold every register
      endcase
    end
  end

  assign status        = {q_r[0], q_1_r, fin};
  assign product       = {a_r[WIDTH-1:0], q_r};
  assign product_valid = pv_r;

endmodule
